// File: rtl/spi_trigger_ctrl_if.sv
// Byte stream from the SPI sniffer/decoder into the trigger sequencer.
// All three signals are asynchronous to the sequencer clock.
interface spi_trigger_ctrl_if;
   logic       spi_cs;
   logic [7:0] spi_data;
   logic       spi_data_rdy;

   modport master (
      output spi_cs,
      output spi_data,
      output spi_data_rdy
   );

   modport slave (
      input spi_cs,
      input spi_data,
      input spi_data_rdy
   );
endinterface

// File: rtl/spi_trigger_ctrl.sv
// SPI byte-sequence trigger: syncs decoder strobes into clk, walks a
// masked byte pattern within one chip-select frame and fires a pulse.
module spi_trigger_ctrl #(
   parameter int PATTERN_BYTES = 8,
   parameter int PULSE_W       = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       enable,
   input  logic                       arm,
   spi_trigger_ctrl_if.slave          spi,
   input  logic [8*PATTERN_BYTES-1:0] cfg_pattern,
   input  logic [8*PATTERN_BYTES-1:0] cfg_mask,
   input  logic [3:0]                 cfg_len,
   input  logic [PULSE_W-1:0]         cfg_pulse_width,
   output logic                       trig_out,
   output logic                       armed,
   output logic [3:0]                 match_idx,
   output logic [15:0]                byte_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_MATCH,
      S_PULSE,
      S_DONE
   } state_e;

   localparam logic [4:0] MAX_LEN = 5'(PATTERN_BYTES);

   state_e               state_q, state_d;
   logic [2:0]           rdy_sync_q, rdy_sync_d;
   logic [2:0]           cs_sync_q, cs_sync_d;
   logic [3:0]           idx_q, idx_d;
   logic [15:0]          bcnt_q, bcnt_d;
   logic [PULSE_W-1:0]   pcnt_q, pcnt_d;
   logic                 trig_q, trig_d;

   logic                 byte_evt;
   logic                 cs_end;
   logic                 len_ok;
   logic                 hit_cur;
   logic                 hit_first;
   logic                 last;
   logic [7:0]           pat_cur;
   logic [7:0]           msk_cur;
   logic [15:0]          bcnt_inc;
   logic [PULSE_W-1:0]   pulse_load;

   function automatic logic [7:0] pick(
      input logic [8*PATTERN_BYTES-1:0] v,
      input logic [3:0]                 i
   );
      logic [7:0] r;
      r = '0;
      for (int k = 0; k < PATTERN_BYTES; k++) begin
         if (i == 4'(k)) r = v[8*k +: 8];
      end
      return r;
   endfunction

   // bit 0 is the first sync stage, bit 2 the last
   assign byte_evt = rdy_sync_q[1] & ~rdy_sync_q[2];
   assign cs_end   = cs_sync_q[1] & ~cs_sync_q[2];

   assign len_ok  = (cfg_len != 4'd0) && ({1'b0, cfg_len} <= MAX_LEN);
   assign pat_cur = pick(cfg_pattern, idx_q);
   assign msk_cur = pick(cfg_mask, idx_q);
   assign last    = (idx_q == cfg_len - 4'd1);

   assign hit_cur   = ((spi.spi_data ^ pat_cur) & msk_cur) == 8'h00;
   assign hit_first = ((spi.spi_data ^ cfg_pattern[7:0])
                       & cfg_mask[7:0]) == 8'h00;

   assign bcnt_inc   = (bcnt_q == 16'hFFFF) ? bcnt_q : bcnt_q + 16'd1;
   assign pulse_load = (cfg_pulse_width == '0) ? PULSE_W'(1)
                                               : cfg_pulse_width;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         rdy_sync_q <= 3'b000;
         cs_sync_q  <= 3'b111;
         idx_q      <= '0;
         bcnt_q     <= '0;
         pcnt_q     <= '0;
         trig_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rdy_sync_q <= rdy_sync_d;
         cs_sync_q  <= cs_sync_d;
         idx_q      <= idx_d;
         bcnt_q     <= bcnt_d;
         pcnt_q     <= pcnt_d;
         trig_q     <= trig_d;
      end
   end

   always_comb begin
      rdy_sync_d = {rdy_sync_q[1:0], spi.spi_data_rdy};
      cs_sync_d  = {cs_sync_q[1:0], spi.spi_cs};
      state_d    = state_q;
      idx_d      = idx_q;
      bcnt_d     = bcnt_q;
      pcnt_d     = pcnt_q;
      if (!enable) begin
         state_d = S_IDLE;
         idx_d   = '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (arm && len_ok) begin
                  state_d = S_ARMED;
                  idx_d   = '0;
                  bcnt_d  = '0;
               end
            end
            S_ARMED, S_MATCH: begin
               if (arm && len_ok) begin
                  state_d = S_ARMED;
                  idx_d   = '0;
                  bcnt_d  = '0;
               end else if (byte_evt) begin
                  // byte wins over a coincident deselect
                  bcnt_d = bcnt_inc;
                  if (hit_cur && last) begin
                     state_d = S_PULSE;
                     idx_d   = cfg_len;
                     pcnt_d  = pulse_load;
                  end else if (cs_end) begin
                     state_d = S_ARMED;
                     idx_d   = '0;
                  end else if (hit_cur) begin
                     state_d = S_MATCH;
                     idx_d   = idx_q + 4'd1;
                  end else if (hit_first) begin
                     state_d = S_MATCH;
                     idx_d   = 4'd1;
                  end else begin
                     state_d = S_ARMED;
                     idx_d   = '0;
                  end
               end else if (cs_end) begin
                  state_d = S_ARMED;
                  idx_d   = '0;
               end
            end
            S_PULSE: begin
               if (pcnt_q <= PULSE_W'(1)) begin
                  state_d = S_DONE;
                  idx_d   = '0;
               end else begin
                  pcnt_d = pcnt_q - PULSE_W'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               idx_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      trig_d = (state_d == S_PULSE);
      armed  = (state_q == S_ARMED) || (state_q == S_MATCH);
   end

   assign trig_out   = trig_q;
   assign match_idx  = idx_q;
   assign byte_count = bcnt_q;

endmodule
